// File: rtl/wrr_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// weighted round-robin ready/valid arbiter.
package wrr_arb_pkg;

    localparam int ARB_DATA_W      = 16;
    localparam int ARB_NUM_REQ     = 4;
    localparam int ARB_WEIGHT_W    = 3;
    localparam int ARB_ORDER_DEPTH = 8;
    localparam int MAX_REQ         = 32;
    localparam int MAX_IDX_W       = $clog2(MAX_REQ);

    typedef logic [$clog2(ARB_NUM_REQ)-1:0] port_idx_t;
    typedef logic [ARB_WEIGHT_W-1:0]        weight_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // First valid port after 'last' with wrap-around; last+1 when none is valid.
    function automatic int rr_pick(input logic [MAX_REQ-1:0] valid,
                                   input int                 last,
                                   input int                 num_req);
        int                   pick;
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
        pick  = (last + 1) % num_req;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = MAX_IDX_W'((last + k) % num_req);
            if (!found && (k <= num_req) && valid[idx]) begin
                pick  = int'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wrr_order_fifo.sv
// Order FIFO remembering which port owns each outstanding request so that
// in-order responses can be routed back; full/empty come from the registered count.
module wrr_order_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wrr_rv_arbiter.sv
// Weighted round-robin arbiter sharing one request/response channel pair
// between NUM_REQ requesters, with burst locking and in-order response routing.
module wrr_rv_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int DATA_W      = ARB_DATA_W,
    parameter int NUM_REQ     = ARB_NUM_REQ,
    parameter int WEIGHT_W    = ARB_WEIGHT_W,
    parameter int ORDER_DEPTH = ARB_ORDER_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ*WEIGHT_W-1:0]      weights,
    input  logic [NUM_REQ*DATA_W-1:0]        req_request_data,
    input  logic [NUM_REQ-1:0]               req_request_valid,
    output logic [NUM_REQ-1:0]               req_request_ready,
    output logic [NUM_REQ*DATA_W-1:0]        req_response_data,
    output logic [NUM_REQ-1:0]               req_response_valid,
    input  logic [NUM_REQ-1:0]               req_response_ready,
    output logic [DATA_W-1:0]                out_req_data,
    output logic                             out_req_valid,
    input  logic                             out_req_ready,
    input  logic [DATA_W-1:0]                out_rsp_data,
    input  logic                             out_rsp_valid,
    output logic                             out_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]       grant,
    output logic [$clog2(ORDER_DEPTH+1)-1:0] outstanding,
    output logic                             err_unexpected_rsp
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [WEIGHT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic              err_q, err_d;

    logic [WEIGHT_W-1:0] weight_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr   [NUM_REQ];
    logic [WEIGHT_W-1:0] eff_weight;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IDX_W-1:0]    head;
    logic                xfer;
    logic                rsp_xfer;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            weight_arr[i] = weights[i*WEIGHT_W +: WEIGHT_W];
            data_arr[i]   = req_request_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        if (state_q == LOCKED) begin
            grant = cur_q;
        end else begin
            grant = IDX_W'(rr_pick(MAX_REQ'(req_request_valid), int'(last_q), NUM_REQ));
        end
    end

    assign out_req_valid = req_request_valid[grant] & ~fifo_full;
    assign out_req_data  = data_arr[grant];
    assign xfer          = out_req_valid & out_req_ready;
    assign eff_weight    = (weight_arr[grant] == '0) ? WEIGHT_W'(1) : weight_arr[grant];

    always_comb begin
        req_request_ready        = '0;
        req_request_ready[grant] = out_req_ready & ~fifo_full;
    end

    // An owner that stops asking releases the lock instead of holding empty slots.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_d       = cur_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (eff_weight == WEIGHT_W'(1)) begin
                        last_d = grant;
                    end else begin
                        state_d     = LOCKED;
                        cur_d       = grant;
                        burst_cnt_d = eff_weight - WEIGHT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (!req_request_valid[cur_q]) begin
                    state_d = IDLE;
                    last_d  = cur_q;
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q - WEIGHT_W'(1);
                    if (burst_cnt_q == WEIGHT_W'(1)) begin
                        state_d = IDLE;
                        last_d  = cur_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    wrr_order_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (grant),
        .pop       (rsp_xfer),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    assign req_response_data = {NUM_REQ{out_rsp_data}};
    assign out_rsp_ready     = ~fifo_empty & req_response_ready[head];
    assign rsp_xfer          = out_rsp_valid & out_rsp_ready;
    assign err_d             = err_q | (out_rsp_valid & fifo_empty);
    assign err_unexpected_rsp = err_q;

    always_comb begin
        req_response_valid       = '0;
        req_response_valid[head] = ~fifo_empty & out_rsp_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            cur_q       <= '0;
            burst_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_q       <= cur_d;
            burst_cnt_q <= burst_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_wrr_rv_arbiter.sv
// Directed scoreboard bench for wrr_rv_arbiter: grant order, weights,
// early release, backpressure, response routing, error flag and reset.
module tb_wrr_rv_arbiter;

    localparam int DATA_W      = 16;
    localparam int NUM_REQ     = 4;
    localparam int WEIGHT_W    = 3;
    localparam int ORDER_DEPTH = 8;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [NUM_REQ*WEIGHT_W-1:0]      weights;
    logic [NUM_REQ*DATA_W-1:0]        req_request_data;
    logic [NUM_REQ-1:0]               req_request_valid;
    logic [NUM_REQ-1:0]               req_request_ready;
    logic [NUM_REQ*DATA_W-1:0]        req_response_data;
    logic [NUM_REQ-1:0]               req_response_valid;
    logic [NUM_REQ-1:0]               req_response_ready;
    logic [DATA_W-1:0]                out_req_data;
    logic                             out_req_valid;
    logic                             out_req_ready;
    logic [DATA_W-1:0]                out_rsp_data;
    logic                             out_rsp_valid;
    logic                             out_rsp_ready;
    logic [1:0]                       grant;
    logic [3:0]                       outstanding;
    logic                             err_unexpected_rsp;

    typedef struct packed {
        logic [1:0]        port;
        logic [DATA_W-1:0] data;
    } rsp_t;

    int   errors = 0;
    int   checks = 0;
    int   exp_grant_q[$];
    rsp_t exp_rsp_q[$];

    wrr_rv_arbiter #(
        .DATA_W      (DATA_W),
        .NUM_REQ     (NUM_REQ),
        .WEIGHT_W    (WEIGHT_W),
        .ORDER_DEPTH (ORDER_DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .weights            (weights),
        .req_request_data   (req_request_data),
        .req_request_valid  (req_request_valid),
        .req_request_ready  (req_request_ready),
        .req_response_data  (req_response_data),
        .req_response_valid (req_response_valid),
        .req_response_ready (req_response_ready),
        .out_req_data       (out_req_data),
        .out_req_valid      (out_req_valid),
        .out_req_ready      (out_req_ready),
        .out_rsp_data       (out_rsp_data),
        .out_rsp_valid      (out_rsp_valid),
        .out_rsp_ready      (out_rsp_ready),
        .grant              (grant),
        .outstanding        (outstanding),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [11:0] w, input logic ord_ready);
        req_request_valid = valid;
        weights           = w;
        out_req_ready     = ord_ready;
    endtask

    task automatic driveRsp(input logic valid, input logic [DATA_W-1:0] data, input logic [3:0] ready);
        out_rsp_valid      = valid;
        out_rsp_data       = data;
        req_response_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'h0, 12'h000, 1'b0);
        driveRsp(1'b0, '0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic runGrantSequence(input string tag, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            settle();
            checkOutput({tag, "_valid"}, 32'(out_req_valid), 32'd1);
            if (exp_grant_q.size() == 0) begin
                checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
            end else begin
                g = exp_grant_q.pop_front();
                checkOutput({tag, "_grant"}, 32'(grant), 32'(g));
                checkOutput({tag, "_data"}, 32'(out_req_data), 32'h1000 + 32'(g));
            end
            tick();
        end
    endtask

    initial begin
        rsp_t r;
        int   port2_count;
        req_request_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

        // Reset state
        doReset();
        settle();
        checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("rst_err", 32'(err_unexpected_rsp), 32'd0);
        checkOutput("rst_out_req_valid", 32'(out_req_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(req_request_ready), 32'd0);
        checkOutput("rst_out_rsp_ready", 32'(out_rsp_ready), 32'd0);
        checkOutput("rst_grant", 32'(grant), 32'd0);

        // Equal weights rotate one transfer per cycle
        doReset();
        applyStimulus(4'hF, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1);
        for (int i = 0; i < 8; i++) exp_grant_q.push_back(i % 4);
        runGrantSequence("t1", 8);
        settle();
        checkOutput("t1_outstanding_full", 32'(outstanding), 32'd8);
        checkOutput("t1_blocked", 32'(out_req_valid), 32'd0);

        // Mixed weights, weight 0 behaves as 1
        doReset();
        applyStimulus(4'hF, {3'd2, 3'd0, 3'd1, 3'd3}, 1'b1);
        exp_grant_q = '{0, 0, 0, 1, 2, 3, 3, 0};
        port2_count = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (grant == 2'd2) port2_count++;
            tick();
        end
        checkOutput("t2_port2_count", 32'(port2_count), 32'd1);
        doReset();
        applyStimulus(4'hF, {3'd2, 3'd0, 3'd1, 3'd3}, 1'b1);
        runGrantSequence("t2", 8);

        // Owner drops valid mid-burst and releases the lock
        doReset();
        applyStimulus(4'b0101, {3'd1, 3'd1, 3'd1, 3'd4}, 1'b1);
        settle();
        checkOutput("t3_first_grant", 32'(grant), 32'd0);
        tick();
        settle();
        checkOutput("t3_second_grant", 32'(grant), 32'd0);
        tick();
        applyStimulus(4'b0100, {3'd1, 3'd1, 3'd1, 3'd4}, 1'b1);
        settle();
        checkOutput("t3_locked_grant", 32'(grant), 32'd0);
        checkOutput("t3_locked_novalid", 32'(out_req_valid), 32'd0);
        tick();
        settle();
        checkOutput("t3_release_grant", 32'(grant), 32'd2);
        checkOutput("t3_release_valid", 32'(out_req_valid), 32'd1);
        checkOutput("t3_release_ready", 32'(req_request_ready), 32'b0100);

        // Full order FIFO blocks requests; a pop unblocks one cycle later
        doReset();
        applyStimulus(4'b0010, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1);
        for (int i = 0; i < 8; i++) begin
            settle();
            checkOutput("t4_fill_ready", 32'(req_request_ready), 32'b0010);
            tick();
        end
        driveRsp(1'b1, 16'h0055, 4'h0);
        settle();
        checkOutput("t4_outstanding", 32'(outstanding), 32'd8);
        checkOutput("t4_full_valid", 32'(out_req_valid), 32'd0);
        checkOutput("t4_full_ready", 32'(req_request_ready), 32'd0);
        checkOutput("t4_rsp_stalled", 32'(out_rsp_ready), 32'd0);
        tick();
        driveRsp(1'b1, 16'h0055, 4'b0010);
        settle();
        checkOutput("t4_pop_ready", 32'(out_rsp_ready), 32'd1);
        checkOutput("t4_pop_rsp_valid", 32'(req_response_valid), 32'b0010);
        checkOutput("t4_pop_no_unblock", 32'(out_req_valid), 32'd0);
        tick();
        driveRsp(1'b0, 16'h0000, 4'h0);
        settle();
        checkOutput("t4_after_pop_count", 32'(outstanding), 32'd7);
        checkOutput("t4_after_pop_valid", 32'(out_req_valid), 32'd1);
        tick();
        settle();
        checkOutput("t4_refilled", 32'(outstanding), 32'd8);
        checkOutput("t4_err_clear", 32'(err_unexpected_rsp), 32'd0);

        // Responses route back in request order
        doReset();
        driveRsp(1'b0, 16'h0000, 4'hF);
        for (int k = 0; k < 3; k++) begin
            r.port = (k == 0) ? 2'd2 : ((k == 1) ? 2'd0 : 2'd3);
            r.data = (k == 0) ? 16'h00A1 : ((k == 1) ? 16'h00B2 : 16'h00C3);
            applyStimulus(4'(1 << r.port), {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1);
            exp_rsp_q.push_back(r);
            settle();
            checkOutput("t5_req_grant", 32'(grant), 32'(r.port));
            tick();
        end
        applyStimulus(4'h0, {3'd1, 3'd1, 3'd1, 3'd1}, 1'b1);
        settle();
        checkOutput("t5_outstanding", 32'(outstanding), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (exp_rsp_q.size() == 0) begin
                checkOutput("t5_queue_empty", 32'd1, 32'd0);
            end else begin
                r = exp_rsp_q[0];
                if (k == 1) begin
                    driveRsp(1'b1, r.data, 4'hF & ~4'(1 << r.port));
                    settle();
                    checkOutput("t5_stall_valid", 32'(req_response_valid), 32'(1 << r.port));
                    checkOutput("t5_stall_ready", 32'(out_rsp_ready), 32'd0);
                    tick();
                    settle();
                    checkOutput("t5_stall_count", 32'(outstanding), 32'd2);
                end
                driveRsp(1'b1, r.data, 4'hF);
                settle();
                checkOutput("t5_rsp_valid", 32'(req_response_valid), 32'(1 << r.port));
                checkOutput("t5_rsp_data", 32'(req_response_data[r.port*DATA_W +: DATA_W]), 32'(r.data));
                checkOutput("t5_rsp_ready", 32'(out_rsp_ready), 32'd1);
                void'(exp_rsp_q.pop_front());
                tick();
            end
        end
        driveRsp(1'b0, 16'h0000, 4'hF);
        settle();
        checkOutput("t5_drained", 32'(outstanding), 32'd0);
        checkOutput("t5_err_clear", 32'(err_unexpected_rsp), 32'd0);

        // Unexpected response flag, then reset in the middle of a burst
        doReset();
        driveRsp(1'b1, 16'hDEAD, 4'hF);
        settle();
        checkOutput("t6_unexp_ready", 32'(out_rsp_ready), 32'd0);
        checkOutput("t6_unexp_rsp_valid", 32'(req_response_valid), 32'd0);
        checkOutput("t6_err_not_yet", 32'(err_unexpected_rsp), 32'd0);
        tick();
        driveRsp(1'b0, 16'h0000, 4'hF);
        settle();
        checkOutput("t6_err_set", 32'(err_unexpected_rsp), 32'd1);
        tick();
        tick();
        settle();
        checkOutput("t6_err_sticky", 32'(err_unexpected_rsp), 32'd1);
        applyStimulus(4'b0100, {3'd1, 3'd4, 3'd1, 3'd1}, 1'b1);
        settle();
        checkOutput("t6_burst_grant", 32'(grant), 32'd2);
        tick();
        applyStimulus(4'hF, {3'd1, 3'd4, 3'd1, 3'd1}, 1'b1);
        settle();
        checkOutput("t6_burst_locked", 32'(grant), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        checkOutput("t6_rst_grant", 32'(grant), 32'd0);
        checkOutput("t6_rst_outstanding", 32'(outstanding), 32'd0);
        checkOutput("t6_rst_err", 32'(err_unexpected_rsp), 32'd0);
        checkOutput("t6_rst_valid", 32'(out_req_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
